// File: rtl/mtr_ctrl_pkg.sv
// Shared types and helpers for the motor ramp controller.
//   SPD_W        : width of a signed speed word
//   spd_t        : signed speed word, two's complement
//   ramp_state_t : controller states
//   clip_spd()   : symmetric saturation of a speed word to +/-lim
package mtr_ctrl_pkg;

  localparam int SPD_W = 12;

  typedef logic signed [SPD_W-1:0] spd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2,
    STOP = 2'd3
  } ramp_state_t;

  function automatic spd_t clip_spd(input spd_t v, input spd_t lim);
    spd_t r;
    r = v;
    if (v > lim)       r = lim;
    else if (v < -lim) r = -lim;
    return r;
  endfunction

endpackage

// File: rtl/mtr_ramp_ctrl_if.sv
// Target command channel into the ramp controller.
//   cmd_vld  : new target pair present
//   cmd_rdy  : controller accepts a target this cycle
//   cmd_lft  : signed left target
//   cmd_rght : signed right target
// master drives the command, slave is the ramp controller.
interface mtr_ramp_ctrl_if;
  import mtr_ctrl_pkg::*;

  logic cmd_vld;
  logic cmd_rdy;
  spd_t cmd_lft;
  spd_t cmd_rght;

  modport master (output cmd_vld, output cmd_lft, output cmd_rght, input cmd_rdy);
  modport slave  (input cmd_vld, input cmd_lft, input cmd_rght, output cmd_rdy);
endinterface

// File: rtl/spd_slew.sv
// Per-side slew limiter: on each tick moves spd toward tgt by at most step,
// landing exactly on tgt when within one step.
//   clk, rst : clock, synchronous active-high reset
//   tick     : ramp tick, one step allowed on this edge
//   step     : unsigned magnitude of one step
//   tgt      : signed target
//   spd      : registered signed speed output
//   at_tgt   : spd equals tgt
module spd_slew
  import mtr_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [SPD_W-1:0] step,
  input  spd_t             tgt,
  output spd_t             spd,
  output logic             at_tgt
);

  logic signed [SPD_W:0] diff;
  logic        [SPD_W:0] mag;
  spd_t                  spd_nxt;

  // Difference is taken one bit wider so opposite-sign extremes cannot wrap.
  // When |diff| > step the stepped value lies strictly between spd and tgt,
  // so it never overshoots and always fits in SPD_W bits.
  always_comb begin
    diff    = {tgt[SPD_W-1], tgt} - {spd[SPD_W-1], spd};
    mag     = diff[SPD_W] ? (SPD_W+1)'(-diff) : (SPD_W+1)'(diff);
    spd_nxt = spd;
    if (mag <= {1'b0, step})  spd_nxt = tgt;
    else if (diff[SPD_W])     spd_nxt = spd - spd_t'(step);
    else                      spd_nxt = spd + spd_t'(step);
  end

  always_ff @(posedge clk) begin
    if (rst)       spd <= '0;
    else if (tick) spd <= spd_nxt;
  end

  assign at_tgt = (spd == tgt);

endmodule

// File: rtl/mtr_ramp_ctrl.sv
// Slew-rate limiting command sequencer feeding MtrDrv. Accepts signed
// left/right targets over a valid/ready channel and ramps the speed outputs
// toward them one step per prescaled tick; estop ramps both sides to zero
// at the faster ESTOP_STEP rate.
//   clk, rst  : clock, synchronous active-high reset
//   cmd       : target command channel (slave side)
//   estop     : level-sensitive emergency stop
//   lft_spd   : registered signed left speed command
//   rght_spd  : registered signed right speed command
//   at_tgt    : both outputs equal their latched targets
//   stopping  : controller is in STOP
module mtr_ramp_ctrl
  import mtr_ctrl_pkg::*;
#(
  parameter int RAMP_DIV   = 1024,
  parameter int STEP       = 8,
  parameter int ESTOP_STEP = 64,
  parameter int SPD_MAX    = 2047
) (
  input  logic            clk,
  input  logic            rst,
  mtr_ramp_ctrl_if.slave  cmd,
  input  logic            estop,
  output spd_t            lft_spd,
  output spd_t            rght_spd,
  output logic            at_tgt,
  output logic            stopping
);

  localparam spd_t SPD_LIM = spd_t'(SPD_MAX);

  ramp_state_t      state, state_nxt;
  logic [15:0]      pre_cnt;
  logic             tick;
  logic             acc;
  spd_t             tgt_l, tgt_r;
  spd_t             clip_l, clip_r;
  logic [SPD_W-1:0] step;
  logic             lft_at, rght_at;

  assign tick        = (pre_cnt == 16'(RAMP_DIV - 1));
  assign cmd.cmd_rdy = !rst && (state != STOP) && !estop;
  assign acc         = cmd.cmd_vld && cmd.cmd_rdy;
  assign clip_l      = clip_spd(cmd.cmd_lft, SPD_LIM);
  assign clip_r      = clip_spd(cmd.cmd_rght, SPD_LIM);
  assign step        = (state == STOP) ? SPD_W'(ESTOP_STEP) : SPD_W'(STEP);
  assign at_tgt      = lft_at && rght_at;
  assign stopping    = (state == STOP);

  // Free-running prescaler; command acceptance never restarts it.
  always_ff @(posedge clk) begin
    if (rst)       pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 16'd1;
  end

  // Targets are held at zero from the edge that first samples estop until
  // STOP is left, so the slew units ramp to zero without extra muxing.
  always_ff @(posedge clk) begin
    if (rst || estop || state == STOP) begin
      tgt_l <= '0;
      tgt_r <= '0;
    end else if (acc) begin
      tgt_l <= clip_l;
      tgt_r <= clip_r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (acc && (clip_l != '0 || clip_r != '0)) state_nxt = RAMP;
      RAMP: if (!acc && at_tgt)
              state_nxt = (tgt_l == '0 && tgt_r == '0) ? IDLE : HOLD;
      HOLD: if (acc && (clip_l != lft_spd || clip_r != rght_spd)) state_nxt = RAMP;
      STOP: if (!estop && lft_spd == '0 && rght_spd == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (estop) state_nxt = STOP;
  end

  spd_slew u_slew_lft (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .step   (step),
    .tgt    (tgt_l),
    .spd    (lft_spd),
    .at_tgt (lft_at)
  );

  spd_slew u_slew_rght (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .step   (step),
    .tgt    (tgt_r),
    .spd    (rght_spd),
    .at_tgt (rght_at)
  );

endmodule
